// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and width helpers for the return-address stack
// Holds the PC width, the default stack depth and pointer/count width derivations.
package cpu_pkg;
  localparam int PC_WIDTH = 10;
  localparam int CALL_STACK_DEPTH = 8;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/call_stack_if.sv
// call_stack_if: control-unit <-> return-address stack strobes and status
// master: control unit (drives push/pop/d_in); slave: the stack (drives d_out and status).
interface call_stack_if import cpu_pkg::*; #(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = CALL_STACK_DEPTH
);
  logic push;
  logic pop;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic empty;
  logic full;
  logic [cnt_w(DEPTH)-1:0] count;
  logic overflow;
  logic underflow;
  modport master (output push, pop, d_in, input d_out, empty, full, count, overflow, underflow);
  modport slave (input push, pop, d_in, output d_out, empty, full, count, overflow, underflow);
endinterface

// File: rtl/call_stack_mem.sv
// call_stack_mem: DEPTH x WIDTH register array, one sync write port, one async read port, no reset
// Ports: clk, we/wa/wd write port, ra/rd combinational read port.
module call_stack_mem import cpu_pkg::*; #(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = CALL_STACK_DEPTH
) (
  input  logic clk,
  input  logic we,
  input  logic [ptr_w(DEPTH)-1:0] wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [ptr_w(DEPTH)-1:0] ra,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/call_stack.sv
// call_stack: hardware return-address stack executing control-unit push/pop strobes
// Ports: clk; reset (async, active-low); bus (call_stack_if.slave: push, pop, d_in,
// d_out, empty, full, count, overflow, underflow).
// Optional: define CALL_STACK_WRAP_EN so a push while full overwrites the oldest entry.
module call_stack import cpu_pkg::*; #(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = CALL_STACK_DEPTH
) (
  input logic clk,
  input logic reset,
  call_stack_if.slave bus
);
  localparam int SW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
`ifdef CALL_STACK_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic [SW-1:0] sp;
  logic [CW-1:0] count;
  logic overflow, underflow;
  logic empty, full, replace, we;
  logic [SW-1:0] top, wa;
  logic [WIDTH-1:0] rd;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign top = sp - 1'b1;
  // push+pop on a non-empty stack rewrites the top in place
  assign replace = bus.push && bus.pop && !empty;
  assign we = bus.push && (replace || !full || WRAP);
  assign wa = replace ? top : sp;
  call_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .wa(wa), .wd(bus.d_in), .ra(top), .rd(rd)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (replace) begin
    end else if (bus.push) begin
      if (!full) begin
        sp <= sp + 1'b1;
        count <= count + 1'b1;
      end else begin
        overflow <= 1'b1;
        if (WRAP) sp <= sp + 1'b1;
      end
    end else if (bus.pop) begin
      if (!empty) begin
        sp <= sp - 1'b1;
        count <= count - 1'b1;
      end else underflow <= 1'b1;
    end
  assign bus.d_out = empty ? '0 : rd;
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.count = count;
  assign bus.overflow = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: randomized + directed self-checking bench for call_stack against a queue model
module tb_call_stack;
  localparam int W = 10;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int model_q[$];
  logic m_ov = 1'b0;
  logic m_uf = 1'b0;
  call_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();
  call_stack #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) begin
      model_q = {};
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else if (bus.push && bus.pop && model_q.size() > 0) model_q[model_q.size()-1] = int'(bus.d_in);
    else if (bus.push) begin
      if (model_q.size() < D) model_q.push_back(int'(bus.d_in));
      else begin
        m_ov = 1'b1;
`ifdef CALL_STACK_WRAP_EN
        void'(model_q.pop_front());
        model_q.push_back(int'(bus.d_in));
`endif
      end
    end else if (bus.pop) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
      else m_uf = 1'b1;
    end

  always @(negedge clk) begin
    chk("d_out", 32'(bus.d_out), model_q.size() > 0 ? 32'(model_q[model_q.size()-1]) : 32'h0);
    chk("count", 32'(bus.count), 32'(model_q.size()));
    chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
    chk("full", 32'(bus.full), 32'(model_q.size() == D));
    chk("overflow", 32'(bus.overflow), 32'(m_ov));
    chk("underflow", 32'(bus.underflow), 32'(m_uf));
  end

  task automatic cyc(input logic p, input logic q, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    bus.push = p;
    bus.pop = q;
    bus.d_in = d;
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.d_in = '0;
    #12;
    chk("rst_dout", 32'(bus.d_out), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_flags", {bus.overflow, bus.underflow}, 0);
    cyc(0, 0, 0);
    reset = 1'b1;
    cyc(1, 0, 10'h011);
    cyc(1, 0, 10'h022);
    cyc(0, 0, 0);
    chk("pre_rst_count", 32'(bus.count), 2);
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 0);
    chk("async_rst_dout", 32'(bus.d_out), 0);
    chk("async_rst_empty", 32'(bus.empty), 1);
    cyc(0, 0, 0);
    reset = 1'b1;
    cyc(1, 0, 10'h011);
    cyc(1, 0, 10'h022);
    cyc(1, 0, 10'h033);
    cyc(0, 0, 0);
    chk("lifo_count", 32'(bus.count), 3);
    chk("lifo_top", 32'(bus.d_out), 10'h033);
    cyc(0, 1, 0);
    chk("pop1", 32'(bus.d_out), 10'h033);
    cyc(0, 1, 0);
    chk("pop2", 32'(bus.d_out), 10'h022);
    cyc(0, 1, 0);
    chk("pop3", 32'(bus.d_out), 10'h011);
    cyc(0, 0, 0);
    chk("drained_empty", 32'(bus.empty), 1);
    chk("drained_dout", 32'(bus.d_out), 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, W'(i));
    cyc(1, 0, 10'h005);
    chk("full_flag", 32'(bus.full), 1);
    cyc(0, 0, 0);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 4);
`ifdef CALL_STACK_WRAP_EN
    chk("ovf_top", 32'(bus.d_out), 10'h005);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0);
      chk("wrap_pop", 32'(bus.d_out), 32'(5 - i));
    end
`else
    chk("ovf_top", 32'(bus.d_out), 10'h004);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0);
      chk("drop_pop", 32'(bus.d_out), 32'(4 - i));
    end
`endif
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("udf_flag", 32'(bus.underflow), 1);
    chk("udf_count", 32'(bus.count), 0);
    chk("udf_dout", 32'(bus.d_out), 0);
    cyc(1, 0, 10'h077);
    cyc(0, 1, 0);
    chk("udf_sticky", 32'(bus.underflow), 1);
    cyc(0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rst_clears_flags", {bus.overflow, bus.underflow}, 0);
    cyc(0, 0, 0);
    reset = 1'b1;
    cyc(1, 0, 10'h0AA);
    cyc(1, 1, 10'h0BB);
    chk("replace_old", 32'(bus.d_out), 10'h0AA);
    cyc(0, 0, 0);
    chk("replace_new", 32'(bus.d_out), 10'h0BB);
    chk("replace_count", 32'(bus.count), 1);
    cyc(0, 1, 0);
    cyc(1, 1, 10'h0CC);
    cyc(0, 0, 0);
    chk("pp_empty_dout", 32'(bus.d_out), 10'h0CC);
    chk("pp_empty_count", 32'(bus.count), 1);
    chk("pp_empty_udf", 32'(bus.underflow), 0);
    cyc(0, 1, 0);
    cyc(1, 0, 10'h011);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("ret_addr", 32'(bus.d_out), 10'h011);
    cyc(0, 0, 0);
    chk("ret_count", 32'(bus.count), 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40, W'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        chk("rand_rst_count", 32'(bus.count), 0);
        #1;
        reset = 1'b1;
      end
    end
    cyc(0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
